// File: rtl/stack_pkg.sv
// Shared types and constants for the operand-stack sequencing controller.
package stack_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        WR   = 3'd2,
        DEC  = 3'd3,
        RD   = 3'd4,
        CAP  = 3'd5
    } state_t;

    localparam int STACK_DEPTH_DEFAULT = 31;

endpackage

// File: rtl/stack_err_flags.sv
// Sticky overflow/underflow flags; clear has priority over set.
module stack_err_flags (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic set_ovf,
    input  logic set_unf,
    output logic err_ovf,
    output logic err_unf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (clr) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (set_ovf) err_ovf <= 1'b1;
            if (set_unf) err_unf <= 1'b1;
        end
    end

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop sequencer driving an external pointer counter and synchronous stack RAM.
// Optional sticky error flags are built only when STACK_ERR_EN is defined.
//
// state | meaning
// INIT  | zero the external counter (it has no reset of its own)
// IDLE  | wait for clr / push / pop
// WR    | write latched din at sp, increment pointer
// DEC   | decrement pointer
// RD    | read RAM at the new sp
// CAP   | capture read data into dout
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int SIZE  = 5,
    parameter int WIDTH = 8,
    parameter int DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic [SIZE-1:0]  sp,
    output logic             ld,
    output logic             incr,
    output logic             decr,
    output logic             mem_we,
    output logic             mem_re,
    output logic [SIZE-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic             err_ovf,
    output logic             err_unf
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] din_q;
    logic             push_ok;

    assign full      = (sp == SIZE'(DEPTH));
    assign empty     = (sp == '0);
    assign busy      = (state_q != IDLE);
    assign mem_addr  = sp;
    assign mem_wdata = din_q;
    assign push_ok   = (state_q == IDLE) && !clr && push && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        incr    = 1'b0;
        decr    = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            INIT: begin
                ld      = 1'b1;
                state_d = IDLE;
            end
            IDLE: begin
                // push wins over a simultaneous pop; the pop is simply dropped
                if (clr)                ld      = clr;
                else if (push)          state_d = full ? IDLE : WR;
                else if (pop && !empty) state_d = DEC;
            end
            WR: begin
                mem_we  = 1'b1;
                incr    = 1'b1;
                state_d = IDLE;
            end
            DEC: begin
                decr    = 1'b1;
                state_d = RD;
            end
            RD: begin
                mem_re  = 1'b1;
                state_d = CAP;
            end
            CAP:     state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (push_ok) din_q <= din;
            if (state_q == CAP) dout <= mem_rdata;
            dout_valid <= (state_q == CAP);
        end
    end

`ifdef STACK_ERR_EN
    logic set_ovf, set_unf, clr_err;

    assign set_ovf = (state_q == IDLE) && !clr && push && full;
    assign set_unf = (state_q == IDLE) && !clr && !push && pop && empty;
    assign clr_err = (state_q == IDLE) && clr;

    stack_err_flags u_err_flags (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_err),
        .set_ovf (set_ovf),
        .set_unf (set_unf),
        .err_ovf (err_ovf),
        .err_unf (err_unf)
    );
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

endmodule
